// File: rtl/sad_pkg.sv
// Shared constants and FSM state encoding for the SAD difference packer
// and the downstream compressor stage.
package sad_pkg;
   localparam int PIX_W = 8;
   localparam int LANES = 8;
   localparam int SUM_W = 11;

   typedef logic [0:0] state_t;
   localparam state_t FILL = 1'b0;
   localparam state_t HOLD = 1'b1;
endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a-b|; result always fits in W bits.
module abs_diff #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] d
);
   assign d = (a >= b) ? (a - b) : (b - a);
endmodule

// File: rtl/sad_diff_packer.sv
// Packs |a-b| of accepted pixel pairs into 8-lane bundles for the compressor
// array; a bundle closes on the 8th pair or on a pair flagged i_last.
module sad_diff_packer #(
   parameter int PIX_W = 8,
   parameter int LANES = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [PIX_W-1:0] i_pix_a,
   input  logic [PIX_W-1:0] i_pix_b,
   input  logic             i_last,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [PIX_W-1:0] o_p0,
   output logic [PIX_W-1:0] o_p1,
   output logic [PIX_W-1:0] o_p2,
   output logic [PIX_W-1:0] o_p3,
   output logic [PIX_W-1:0] o_p4,
   output logic [PIX_W-1:0] o_p5,
   output logic [PIX_W-1:0] o_p6,
   output logic [PIX_W-1:0] o_p7,
   output logic [3:0]       o_count,
   output logic             o_last
);
   import sad_pkg::*;

   localparam int IDX_W = $clog2(LANES);

   logic [PIX_W-1:0]             diff;
   state_t                       state;
   logic [IDX_W-1:0]             wr_idx;
   logic [3:0]                   cnt;
   logic                         last_q;
   logic [LANES-1:0][PIX_W-1:0]  lanes;
   logic                         accept;
   logic                         drain;
   logic                         close;

   abs_diff #(.W(PIX_W)) u_abs_diff (
      .a (i_pix_a),
      .b (i_pix_b),
      .d (diff)
   );

   // In HOLD a new pair is only taken when the held bundle leaves this same edge.
   assign o_ready = (state == FILL) || i_ready;
   assign accept  = i_valid && o_ready;
   assign drain   = (state == HOLD) && i_ready;
   assign close   = accept && ((wr_idx == IDX_W'(LANES - 1)) || i_last);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= FILL;
         wr_idx <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
         lanes  <= '0;
      end else if (i_clr) begin
         state  <= FILL;
         wr_idx <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
         lanes  <= '0;
      end else if (state == FILL) begin
         if (accept) begin
            lanes[wr_idx] <= diff;
            if (close) begin
               state  <= HOLD;
               cnt    <= {1'b0, wr_idx} + 4'd1;
               last_q <= i_last;
               wr_idx <= '0;
            end else begin
               wr_idx <= wr_idx + IDX_W'(1);
            end
         end
      end else if (drain) begin
         // Fresh bundle: cleared lanes, optionally seeded with the pair taken this edge.
         state  <= FILL;
         wr_idx <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
         lanes  <= '0;
         if (accept) begin
            lanes[0] <= diff;
            if (i_last) begin
               state  <= HOLD;
               cnt    <= 4'd1;
               last_q <= 1'b1;
            end else begin
               wr_idx <= IDX_W'(1);
            end
         end
      end
   end

   assign o_valid = (state == HOLD);
   assign o_count = cnt;
   assign o_last  = last_q;
   assign o_p0    = lanes[0];
   assign o_p1    = lanes[1];
   assign o_p2    = lanes[2];
   assign o_p3    = lanes[3];
   assign o_p4    = lanes[4];
   assign o_p5    = lanes[5];
   assign o_p6    = lanes[6];
   assign o_p7    = lanes[7];
endmodule

// File: tb/tb_sad_diff_packer.sv
// Directed checks of bundle packing, backpressure, flush and reset,
// plus a continuous random stream checked against a sum model.
module tb_sad_diff_packer;
   logic       clk, rst_n, clr, valid, ready_o, last, valid_o, ready, last_o;
   logic [7:0] pa, pb, p0, p1, p2, p3, p4, p5, p6, p7;
   logic [3:0] count;
   int         n_tests, n_fail;

   sad_diff_packer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_valid(valid), .o_ready(ready_o),
      .i_pix_a(pa), .i_pix_b(pb), .i_last(last), .o_valid(valid_o), .i_ready(ready),
      .o_p0(p0), .o_p1(p1), .o_p2(p2), .o_p3(p3), .o_p4(p4), .o_p5(p5), .o_p6(p6),
      .o_p7(p7), .o_count(count), .o_last(last_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one pair across one rising edge; returns #1 after that edge.
   task automatic send(input int a, input int b, input logic l);
      @(negedge clk);
      valid = 1'b1; pa = 8'(a); pb = 8'(b); last = l;
      @(posedge clk);
      #1 valid = 1'b0; last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int lane_sum();
      return int'(p0) + int'(p1) + int'(p2) + int'(p3) + int'(p4) + int'(p5) + int'(p6) + int'(p7);
   endfunction

   int gold[8];
   int gsum, nb, a_r, b_r, d_r;

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0; clr = 1'b0; valid = 1'b0; last = 1'b0; ready = 1'b1; pa = '0; pb = '0;
      #12;
      chk("rst_valid", valid_o, 0); chk("rst_ready", ready_o, 1);
      chk("rst_count", count, 0);   chk("rst_last", last_o, 0);
      chk("rst_sum", lane_sum(), 0);
      @(negedge clk) rst_n = 1'b1;

      // Full bundle of 8
      send(200, 50, 0); send(1, 2, 0); send(30, 10, 0); send(0, 0, 0);
      send(255, 255, 0); send(100, 200, 0); send(77, 7, 0);
      chk("full_pre_valid", valid_o, 0);
      send(7, 9, 0);
      chk("full_valid", valid_o, 1); chk("full_p0", p0, 150); chk("full_p2", p2, 20);
      chk("full_p5", p5, 100); chk("full_p7", p7, 2);
      chk("full_count", count, 8); chk("full_last", last_o, 0);
      idle(1);
      chk("drain_valid", valid_o, 0); chk("drain_count", count, 0); chk("drain_p0", p0, 0);

      // Short bundle closed by last
      send(10, 20, 0); send(255, 0, 0); send(0, 255, 1);
      chk("short_valid", valid_o, 1); chk("short_p0", p0, 10); chk("short_p1", p1, 255);
      chk("short_p2", p2, 255); chk("short_p3", p3, 0); chk("short_p7", p7, 0);
      chk("short_count", count, 3); chk("short_last", last_o, 1);
      idle(1);

      // Backpressure hold, then drain with simultaneous accept
      ready = 1'b0;
      for (int i = 0; i < 8; i++) send(i * 10 + 5, i, 0);
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", valid_o, 1); chk("hold_ready", ready_o, 0);
         chk("hold_p3", p3, 32); chk("hold_p7", p7, 68); chk("hold_count", count, 8);
         idle(1);
      end
      @(negedge clk);
      ready = 1'b1; valid = 1'b1; pa = 8'd9; pb = 8'd4;
      #1 chk("drain_acc_ready", ready_o, 1);
      @(posedge clk); #1 valid = 1'b0;
      chk("reseed_valid", valid_o, 0); chk("reseed_p0", p0, 5); chk("reseed_p1", p1, 0);
      chk("reseed_count", count, 0);
      for (int k = 1; k < 8; k++) send(k, 0, 0);
      chk("reseed_bvalid", valid_o, 1); chk("reseed_bp0", p0, 5);
      chk("reseed_bp7", p7, 7); chk("reseed_bcount", count, 8);
      idle(1);

      // Flush mid-bundle drops the colliding pair
      for (int k = 0; k < 4; k++) send(50, k, 0);
      @(negedge clk);
      clr = 1'b1; valid = 1'b1; pa = 8'd99; pb = 8'd0; last = 1'b1;
      @(posedge clk); #1 clr = 1'b0; valid = 1'b0; last = 1'b0;
      chk("clr_valid", valid_o, 0); chk("clr_p0", p0, 0); chk("clr_sum", lane_sum(), 0);
      for (int k = 0; k < 8; k++) send(k + 1, 0, 0);
      chk("clr_bvalid", valid_o, 1); chk("clr_bcount", count, 8);
      chk("clr_bp0", p0, 1); chk("clr_bsum", lane_sum(), 36);
      idle(1);

      // Asynchronous reset while holding
      ready = 1'b0;
      for (int k = 0; k < 8; k++) send(100, k, 0);
      chk("arst_pre_valid", valid_o, 1);
      @(negedge clk); #2 rst_n = 1'b0;
      #1 chk("arst_valid", valid_o, 0); chk("arst_ready", ready_o, 1);
      chk("arst_count", count, 0); chk("arst_sum", lane_sum(), 0); chk("arst_last", last_o, 0);
      @(negedge clk) rst_n = 1'b1;
      ready = 1'b1;
      for (int k = 0; k < 8; k++) send(0, 3 * k, 0);
      chk("arst_bvalid", valid_o, 1); chk("arst_bcount", count, 8);
      chk("arst_bp7", p7, 21); chk("arst_bsum", lane_sum(), 84);
      idle(1);

      // Continuous random stream, i_ready held high
      nb = 0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         a_r = int'($urandom_range(0, 255)); b_r = int'($urandom_range(0, 255));
         valid = 1'b1; pa = 8'(a_r); pb = 8'(b_r);
         d_r = (a_r >= b_r) ? a_r - b_r : b_r - a_r;
         gold[n % 8] = d_r;
         @(posedge clk); #1;
         if (n % 8 == 7) begin
            gsum = 0;
            for (int j = 0; j < 8; j++) gsum += gold[j];
            chk("rnd_valid", valid_o, 1); chk("rnd_sum", lane_sum(), gsum);
            chk("rnd_p7", p7, gold[7]);
            if (valid_o) nb++;
         end else if (valid_o) begin
            chk("rnd_bubble", n % 8, 7);
         end
      end
      valid = 1'b0;
      chk("rnd_bundles", nb, 125);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sad_diff_packer.md
SAD_DIFF_PACKER -- requirements
Module: sad_diff_packer

Interface
REQ-001 Parameter PIX_W, 8: pixel and lane width; fixed at 8 to match the 8-operand compressor array input width.
REQ-002 Parameter LANES, 8: operands per bundle; fixed at 8.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_clr  input  1  synchronous flush of partial and held bundles.
REQ-006 i_valid  input  1  pixel pair present on i_pix_a/i_pix_b.
REQ-007 o_ready  output  1  block accepts a pair this cycle.
REQ-008 i_pix_a  input  8  current-block pixel.
REQ-009 i_pix_b  input  8  reference-block pixel.
REQ-010 i_last  input  1  pair is the final pair of a SAD block; qualified by i_valid.
REQ-011 o_valid  output  1  bundle o_p0..o_p7 valid.
REQ-012 i_ready  input  1  downstream compressor stage takes the bundle.
REQ-013 o_p0..o_p7  output  8 each  absolute differences; lane k is the k-th accepted pair of the bundle.
REQ-014 o_count  output  4  number of populated lanes, 1..8, valid with o_valid.
REQ-015 o_last  output  1  bundle closes a SAD block.

Function
REQ-016 Pair accepted iff i_valid && o_ready at the rising edge; |i_pix_a - i_pix_b| (8-bit unsigned, range 0..255, no overflow) is written into lane wr_idx.
REQ-017 FSM states: FILL (collecting; o_valid=0) and HOLD (bundle presented; o_valid=1).
REQ-018 FILL -> HOLD on the edge that accepts the 8th pair or any pair with i_last=1; latency is 1 cycle from that accepting edge to o_valid=1.
REQ-019 A bundle closed by i_last with fewer than 8 pairs shall drive unpopulated lanes to 0, o_count=populated lanes, and o_last=1.
REQ-020 In HOLD, o_p*, o_count, and o_last shall be stable until o_valid && i_ready.
REQ-021 o_ready = (state==FILL) || (state==HOLD && i_ready); combinational from i_ready only.
REQ-022 Simultaneous drain and accept in HOLD: the new pair goes to lane 0 of a fresh bundle, all other lanes are cleared, wr_idx=1, and the state becomes FILL (or stays HOLD if that pair has i_last=1, presenting a 1-lane bundle).
REQ-023 Drain without accept: state -> FILL, wr_idx=0, lanes cleared to 0, o_count=0.
REQ-024 i_clr has priority over all handshakes: next state FILL, wr_idx=0, lanes cleared, o_valid=0; a pair presented in the same cycle is dropped.
REQ-025 wr_idx shall wrap from 7 to 0 only via bundle close; it shall never exceed 7.
REQ-026 Back-to-back full bundles with i_ready held at 1 shall sustain one pair per cycle without bubbles.

Reset
REQ-027 While i_rst_n=0: state FILL, wr_idx=0, o_valid=0, o_p0..o_p7=0, o_count=0, o_last=0, o_ready=1.
REQ-028 Reset assertion mid-bundle (FILL or HOLD) shall discard all content immediately and asynchronously; deassertion takes effect on the next rising edge.

Structure
REQ-029 Shared package sad_pkg shall hold PIX_W=8, LANES=8, SUM_W=11 (compressor sum width), and the FILL/HOLD state type.
REQ-030 A single sub-module, abs_diff (8-bit unsigned |a-b|, combinational), shall be instantiated once on the input path.
REQ-031 The lane array shall be implemented as registers; no memory macros shall be used.

Verification
REQ-032 Reset, then 8 pairs (a=200,b=50 … a=7,b=9, i_ready=1) -> one cycle after the 8th accept: o_valid=1, o_p0=150, o_p7=2, o_count=8, o_last=0.
REQ-033 3 pairs (10/20, 255/0, 0/255) with i_last on the 3rd -> o_p0=10, o_p1=255, o_p2=255, o_p3..o_p7=0, o_count=3, o_last=1.
REQ-034 Full bundle held with i_ready=0 for 5 cycles, then i_ready=1 with i_valid=1 (a=9,b=4) -> outputs stable for 5 cycles, o_ready=0, then next bundle lane 0=5 with wr_idx=1.
REQ-035 i_clr pulsed after 4 accepts -> o_valid stays 0; the next 8 pairs form a clean bundle with o_count=8.
REQ-036 i_rst_n dropped while o_valid=1 -> all outputs 0 and o_ready=1 asynchronously; 8 pairs after release -> correct bundle.
REQ-037 Continuous random pairs with i_ready=1 for 1000 cycles -> one bundle every 8 cycles; the sum of lanes equals the compressor golden-model input; no dropped pairs.
